// File: rtl/jtag_dpram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_dpram_pkg
//  Description : Shared types and constants for the JTAG-bridge DPRAM
//                responder: FSM state encoding, burst-count width and the
//                default data word returned for out-of-window reads.
//  Revision    : 1.0  initial release
// ============================================================================
package jtag_dpram_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR_BURST = 2'd1,
      S_RD_ISSUE = 2'd2,
      S_RD_DRAIN = 2'd3
   } state_e;

   localparam int          BURST_W       = 5;
   localparam int          MAX_BURST     = 16;
   localparam logic [31:0] DEF_MISS_DATA = 32'hDEAD_BEEF;

   // Effective beat count: a zero count is a single beat; anything above the
   // largest legal burst is clamped so the beat counter can never run away.
   function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] count);
      if (count == '0) begin
         return BURST_W'(1);
      end
      if (count > BURST_W'(MAX_BURST)) begin
         return BURST_W'(MAX_BURST);
      end
      return count;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_dpram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_dpram_responder_if
//  Description : Avalon-MM burst bus between the JTAG bridge master and the
//                DPRAM responder.
//  Ports       : iADDRESS/iREAD/iWRITE/iWRITE_DATA/iBURST_COUNT  master->slave
//                oWAIT_REQUEST/oREAD_DATA/oREAD_DATAVALID        slave->master
//  Revision    : 1.0  initial release
// ============================================================================
interface jtag_dpram_responder_if;
   import jtag_dpram_pkg::*;

   logic [31:0]        iADDRESS;
   logic               iREAD;
   logic               iWRITE;
   logic [31:0]        iWRITE_DATA;
   logic [BURST_W-1:0] iBURST_COUNT;
   logic               oWAIT_REQUEST;
   logic [31:0]        oREAD_DATA;
   logic               oREAD_DATAVALID;

   modport master (
      output iADDRESS, iREAD, iWRITE, iWRITE_DATA, iBURST_COUNT,
      input  oWAIT_REQUEST, oREAD_DATA, oREAD_DATAVALID
   );

   modport slave (
      input  iADDRESS, iREAD, iWRITE, iWRITE_DATA, iBURST_COUNT,
      output oWAIT_REQUEST, oREAD_DATA, oREAD_DATAVALID
   );

endinterface
`default_nettype wire

// File: rtl/jtag_dpram_responder_rd_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_valid_pipe
//  Description : LATENCY-deep shift register tracking issued RAM reads so the
//                matching read-data-valid (and its miss tag) emerges exactly
//                LATENCY cycles after the issue cycle.
//  Ports       : iCLK, iRESETn      clock, async active-low clear
//                issue_i, miss_i    read issued this cycle / it is a miss
//                valid_o, miss_o    beat returning this cycle / its miss tag
//                busy_o             beats still in flight after this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module rd_valid_pipe #(
   parameter int unsigned LATENCY = 2
) (
   input  logic iCLK,
   input  logic iRESETn,
   input  logic issue_i,
   input  logic miss_i,
   output logic valid_o,
   output logic miss_o,
   output logic busy_o
);

   // Index 0 is the youngest stage, LATENCY-1 the one presented at the output.
   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] miss_q;

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         valid_q <= '0;
         miss_q  <= '0;
      end else begin
         valid_q[0] <= issue_i;
         miss_q[0]  <= miss_i;
         for (int k = 1; k < int'(LATENCY); k++) begin
            valid_q[k] <= valid_q[k-1];
            miss_q[k]  <= miss_q[k-1];
         end
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign miss_o  = miss_q[LATENCY-1];

   // The output stage is excluded: once only it is occupied, the last beat
   // leaves this cycle and the FSM may reopen the bus on the next one.
   always_comb begin
      busy_o = 1'b0;
      for (int k = 0; k < int'(LATENCY) - 1; k++) begin
         busy_o = busy_o | valid_q[k];
      end
   end

endmodule
`default_nettype wire

// File: rtl/jtag_dpram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_dpram_responder
//  Description : Avalon-MM burst slave terminating the JTAG bridge master on
//                one port of the shared 32-bit dual-port RAM. Out-of-window
//                accesses are absorbed (writes dropped, reads return
//                MISS_DATA) and flagged.
//  Ports       : iCLK, iRESETn       clock, async active-low reset
//                bus (slave)         Avalon-MM burst bus
//                oRAM_CS/WE/ADDR/WDATA, iRAM_RDATA   DPRAM port
//                oPROTO_ERR          sticky protocol-violation flag
//                oMISS               sticky out-of-window flag
//  Revision    : 1.0  initial release
// ============================================================================
module jtag_dpram_responder
   import jtag_dpram_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] MISS_DATA    = DEF_MISS_DATA
) (
   input  logic                  iCLK,
   input  logic                  iRESETn,
   jtag_dpram_responder_if.slave bus,
   output logic                  oRAM_CS,
   output logic                  oRAM_WE,
   output logic [ADDR_W-1:0]     oRAM_ADDR,
   output logic [31:0]           oRAM_WDATA,
   input  logic [31:0]           iRAM_RDATA,
   output logic                  oPROTO_ERR,
   output logic                  oMISS
);

   // Byte-offset bits covered by the window (4 bytes per RAM word).
   localparam logic [31:0] WIN_MASK = (32'd1 << (ADDR_W + 2)) - 32'd1;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BURST_W-1:0] remain_q, remain_d;
   logic               hit_q, hit_d;
   logic               proto_q, proto_d;
   logic               miss_q, miss_d;
   logic [31:0]        rdata_q;

   logic               hit_now;
   logic [ADDR_W-1:0]  word_now;
   logic [BURST_W-1:0] len_now;
   logic               rd_issue;
   logic               pipe_valid;
   logic               pipe_miss;
   logic               pipe_busy;
   logic [31:0]        read_data;

   assign hit_now  = ((bus.iADDRESS & ~WIN_MASK) == BASE_ADDR);
   assign word_now = bus.iADDRESS[ADDR_W+1:2];
   assign len_now  = burst_len(bus.iBURST_COUNT);

   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      remain_d          = remain_q;
      hit_d             = hit_q;
      proto_d           = proto_q;
      miss_d            = miss_q;
      bus.oWAIT_REQUEST = 1'b0;
      oRAM_CS           = 1'b0;
      oRAM_WE           = 1'b0;
      oRAM_ADDR         = addr_q;
      oRAM_WDATA        = '0;
      rd_issue          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.iWRITE) begin
               // First beat goes straight to the RAM in the acceptance cycle;
               // a simultaneous read is dropped and flagged.
               oRAM_CS    = hit_now;
               oRAM_WE    = hit_now;
               oRAM_ADDR  = word_now;
               oRAM_WDATA = bus.iWRITE_DATA;
               hit_d      = hit_now;
               miss_d     = miss_q | ~hit_now;
               proto_d    = proto_q | bus.iREAD;
               addr_d     = word_now + ADDR_W'(1);
               remain_d   = len_now - BURST_W'(1);
               if (len_now != BURST_W'(1)) begin
                  state_d = S_WR_BURST;
               end
            end else if (bus.iREAD) begin
               hit_d    = hit_now;
               miss_d   = miss_q | ~hit_now;
               addr_d   = word_now;
               remain_d = len_now;
               state_d  = S_RD_ISSUE;
            end
         end

         S_WR_BURST: begin
            proto_d = proto_q | bus.iREAD;
            // iWRITE low is a master stall: nothing moves.
            if (bus.iWRITE) begin
               oRAM_CS    = hit_q;
               oRAM_WE    = hit_q;
               oRAM_WDATA = bus.iWRITE_DATA;
               addr_d     = addr_q + ADDR_W'(1);
               remain_d   = remain_q - BURST_W'(1);
               if (remain_q == BURST_W'(1)) begin
                  state_d = S_IDLE;
               end
            end
         end

         S_RD_ISSUE: begin
            bus.oWAIT_REQUEST = 1'b1;
            // Misses still run through the pipe so the master always gets
            // its full count of beats.
            oRAM_CS  = hit_q;
            rd_issue = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - BURST_W'(1);
            if (remain_q == BURST_W'(1)) begin
               state_d = S_RD_DRAIN;
            end
         end

         S_RD_DRAIN: begin
            bus.oWAIT_REQUEST = 1'b1;
            if (!pipe_busy) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   rd_valid_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_rd_valid_pipe (
      .iCLK    (iCLK),
      .iRESETn (iRESETn),
      .issue_i (rd_issue),
      .miss_i  (~hit_q),
      .valid_o (pipe_valid),
      .miss_o  (pipe_miss),
      .busy_o  (pipe_busy)
   );

   // Returned beats pass the RAM word through in the valid cycle; between
   // beats the last value is held.
   always_comb begin
      read_data = rdata_q;
      if (pipe_valid) begin
         read_data = pipe_miss ? MISS_DATA : iRAM_RDATA;
      end
   end

   assign bus.oREAD_DATA      = read_data;
   assign bus.oREAD_DATAVALID = pipe_valid;
   assign oPROTO_ERR          = proto_q;
   assign oMISS               = miss_q;

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         hit_q    <= 1'b0;
         proto_q  <= 1'b0;
         miss_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         hit_q    <= hit_d;
         proto_q  <= proto_d;
         miss_q   <= miss_d;
         if (pipe_valid) begin
            rdata_q <= read_data;
         end
      end
   end

endmodule
`default_nettype wire
